// File: rtl/bnn_host_sequencer.sv
// Host-side sequencer for the BNN accelerator: encodes parameter writes onto the
// 784-bit image bus, assembles and launches 28x28 frames, and returns the class.
module bnn_host_sequencer #(
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [2:0]   cmd_type,
   input  logic [27:0]  cmd_data,
   input  logic [4:0]   cmd_a18,
   input  logic [2:0]   cmd_a5,
   input  logic [3:0]   cmd_a10,
   input  logic [5:0]   cmd_a60,
   input  logic [9:0]   cmd_a960,
   output logic [783:0] acc_image,
   output logic [1:0]   kernel_layer,
   output logic [1:0]   offset_layer,
   output logic         image_in_valid,
   input  logic [3:0]   class_out,
   input  logic         class_out_valid,
   output logic         class_out_ready,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [3:0]   res_class,
   output logic         err_addr,
   output logic         err_timeout
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   localparam logic [2:0] CMD_K1      = 3'd1;
   localparam logic [2:0] CMD_K2      = 3'd2;
   localparam logic [2:0] CMD_FCB     = 3'd3;
   localparam logic [2:0] CMD_OFF1    = 3'd4;
   localparam logic [2:0] CMD_OFF2    = 3'd5;
   localparam logic [2:0] CMD_FCM     = 3'd6;
   localparam logic [2:0] CMD_IMG_ROW = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_WAIT   = 2'd2,
      ST_RESULT = 2'd3
   } state_t;

   state_t          state_r, state_nxt_s;
   logic [783:0]    frame_r, frame_nxt_s;
   logic [4:0]      row_r, row_nxt_s;
   logic [9:0]      row_idx_s;
   logic [TW-1:0]   tmo_r, tmo_nxt_s;
   logic [783:0]    img_r, img_nxt_s, enc_s;
   logic [1:0]      kl_r, kl_nxt_s, kl_s;
   logic [1:0]      ol_r, ol_nxt_s, ol_s;
   logic            iiv_r, iiv_nxt_s;
   logic            res_valid_r, res_valid_nxt_s;
   logic [3:0]      res_class_r, res_class_nxt_s;
   logic            err_addr_r, err_addr_nxt_s;
   logic            err_tmo_r, err_tmo_nxt_s;
   logic            addr_ok_s;

   assign row_idx_s       = {5'd0, row_r} * 10'd28;
   assign cmd_ready       = (state_r == ST_IDLE);
   assign class_out_ready = (state_r == ST_WAIT);
   assign acc_image       = img_r;
   assign kernel_layer    = kl_r;
   assign offset_layer    = ol_r;
   assign image_in_valid  = iiv_r;
   assign res_valid       = res_valid_r;
   assign res_class       = res_class_r;
   assign err_addr        = err_addr_r;
   assign err_timeout     = err_tmo_r;

   // Command decode: bus encoding, strobe value and range check of the used address fields
   always_comb begin
      enc_s     = '0;
      kl_s      = 2'd0;
      ol_s      = 2'd0;
      addr_ok_s = 1'b1;
      case (cmd_type)
         CMD_K1: begin
            enc_s[24:0]    = cmd_data[24:0];
            enc_s[116:112] = cmd_a18;
            enc_s[142:140] = cmd_a5;
            kl_s           = 2'd1;
            addr_ok_s      = (cmd_a18 < 5'd18) && (cmd_a5 < 3'd5);
         end
         CMD_K2: begin
            enc_s[24:0]    = cmd_data[24:0];
            enc_s[201:196] = cmd_a60;
            enc_s[116:112] = cmd_a18;
            kl_s           = 2'd2;
            addr_ok_s      = (cmd_a60 < 6'd60) && (cmd_a18 < 5'd18);
         end
         CMD_FCB: begin
            enc_s[84]      = cmd_data[0];
            enc_s[171:168] = cmd_a10;
            enc_s[233:224] = cmd_a960;
            kl_s           = 2'd3;
            addr_ok_s      = (cmd_a10 < 4'd10) && (cmd_a960 < 10'd960);
         end
         CMD_OFF1: begin
            enc_s[90:84]   = cmd_data[6:0];
            enc_s[116:112] = cmd_a18;
            ol_s           = 2'd1;
            addr_ok_s      = (cmd_a18 < 5'd18);
         end
         CMD_OFF2: begin
            enc_s[92:84]   = cmd_data[8:0];
            enc_s[201:196] = cmd_a60;
            ol_s           = 2'd2;
            addr_ok_s      = (cmd_a60 < 6'd60);
         end
         CMD_FCM: begin
            enc_s[91:84]   = cmd_data[7:0];
            enc_s[171:168] = cmd_a10;
            ol_s           = 2'd3;
            addr_ok_s      = (cmd_a10 < 4'd10);
         end
         default: begin
            enc_s     = '0;
            kl_s      = 2'd0;
            ol_s      = 2'd0;
            addr_ok_s = 1'b1;
         end
      endcase
   end

   // Next-state and next-output logic; bus and strobes default to idle every cycle
   always_comb begin
      state_nxt_s     = state_r;
      frame_nxt_s     = frame_r;
      row_nxt_s       = row_r;
      tmo_nxt_s       = tmo_r;
      img_nxt_s       = '0;
      kl_nxt_s        = 2'd0;
      ol_nxt_s        = 2'd0;
      iiv_nxt_s       = 1'b0;
      res_valid_nxt_s = res_valid_r;
      res_class_nxt_s = res_class_r;
      err_addr_nxt_s  = err_addr_r;
      err_tmo_nxt_s   = err_tmo_r;
      case (state_r)
         ST_IDLE: begin
            if (cmd_valid && (cmd_type == CMD_IMG_ROW)) begin
               frame_nxt_s[row_idx_s +: 28] = cmd_data;
               if (row_r == 5'd27) begin
                  row_nxt_s   = 5'd0;
                  img_nxt_s   = frame_nxt_s;
                  iiv_nxt_s   = 1'b1;
                  state_nxt_s = ST_LAUNCH;
               end else begin
                  row_nxt_s = row_r + 5'd1;
               end
            end else if (cmd_valid && !addr_ok_s) begin
               err_addr_nxt_s = 1'b1;
            end else if (cmd_valid) begin
               img_nxt_s = enc_s;
               kl_nxt_s  = kl_s;
               ol_nxt_s  = ol_s;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_LAUNCH: begin
            tmo_nxt_s   = '0;
            state_nxt_s = ST_WAIT;
         end
         ST_WAIT: begin
            // A class arriving in the last allowed cycle still wins over the timeout
            if (class_out_valid) begin
               res_class_nxt_s = class_out;
               res_valid_nxt_s = 1'b1;
               state_nxt_s     = ST_RESULT;
            end else if (tmo_r == TMO_LAST) begin
               err_tmo_nxt_s = 1'b1;
               state_nxt_s   = ST_IDLE;
            end else begin
               tmo_nxt_s = tmo_r + TW'(1);
            end
         end
         ST_RESULT: begin
            if (res_ready) begin
               res_valid_nxt_s = 1'b0;
               state_nxt_s     = ST_IDLE;
            end else begin
               res_valid_nxt_s = 1'b1;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         frame_r     <= '0;
         row_r       <= 5'd0;
         tmo_r       <= '0;
         img_r       <= '0;
         kl_r        <= 2'd0;
         ol_r        <= 2'd0;
         iiv_r       <= 1'b0;
         res_valid_r <= 1'b0;
         res_class_r <= 4'd0;
         err_addr_r  <= 1'b0;
         err_tmo_r   <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         frame_r     <= frame_nxt_s;
         row_r       <= row_nxt_s;
         tmo_r       <= tmo_nxt_s;
         img_r       <= img_nxt_s;
         kl_r        <= kl_nxt_s;
         ol_r        <= ol_nxt_s;
         iiv_r       <= iiv_nxt_s;
         res_valid_r <= res_valid_nxt_s;
         res_class_r <= res_class_nxt_s;
         err_addr_r  <= err_addr_nxt_s;
         err_tmo_r   <= err_tmo_nxt_s;
      end
   end

endmodule

// File: tb/tb_bnn_host_sequencer.sv
// Directed self-checking bench for bnn_host_sequencer: write encoding, range errors,
// frame assembly and launch, class/result handshakes, timeout and reset abort.
module tb_bnn_host_sequencer;

   localparam int TMO = 60;

   logic         clk = 1'b0;
   logic         rst;
   logic         cmd_valid;
   logic         cmd_ready;
   logic [2:0]   cmd_type;
   logic [27:0]  cmd_data;
   logic [4:0]   cmd_a18;
   logic [2:0]   cmd_a5;
   logic [3:0]   cmd_a10;
   logic [5:0]   cmd_a60;
   logic [9:0]   cmd_a960;
   logic [783:0] acc_image;
   logic [1:0]   kernel_layer;
   logic [1:0]   offset_layer;
   logic         image_in_valid;
   logic [3:0]   class_out;
   logic         class_out_valid;
   logic         class_out_ready;
   logic         res_valid;
   logic         res_ready;
   logic [3:0]   res_class;
   logic         err_addr;
   logic         err_timeout;

   int vec_cnt = 0;
   int err_cnt = 0;

   bnn_host_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_type(cmd_type), .cmd_data(cmd_data), .cmd_a18(cmd_a18), .cmd_a5(cmd_a5),
      .cmd_a10(cmd_a10), .cmd_a60(cmd_a60), .cmd_a960(cmd_a960),
      .acc_image(acc_image), .kernel_layer(kernel_layer), .offset_layer(offset_layer),
      .image_in_valid(image_in_valid), .class_out(class_out),
      .class_out_valid(class_out_valid), .class_out_ready(class_out_ready),
      .res_valid(res_valid), .res_ready(res_ready), .res_class(res_class),
      .err_addr(err_addr), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   // One command beat; returns #1 after the accepting edge, where the encoded write is visible
   task automatic drive_cmd(input logic [2:0] t, input logic [27:0] d, input logic [4:0] a18,
                            input logic [2:0] a5, input logic [3:0] a10, input logic [5:0] a60,
                            input logic [9:0] a960);
      cmd_valid = 1'b1; cmd_type = t; cmd_data = d;
      cmd_a18 = a18; cmd_a5 = a5; cmd_a10 = a10; cmd_a60 = a60; cmd_a960 = a960;
      @(posedge clk); #1;
      cmd_valid = 1'b0; cmd_type = 3'd0; cmd_data = 28'd0;
      cmd_a18 = 5'd0; cmd_a5 = 3'd0; cmd_a10 = 4'd0; cmd_a60 = 6'd0; cmd_a960 = 10'd0;
   endtask

   task automatic test_reset();
      rst = 1'b1; cmd_valid = 1'b0; cmd_type = 3'd0; cmd_data = 28'd0;
      cmd_a18 = 5'd0; cmd_a5 = 3'd0; cmd_a10 = 4'd0; cmd_a60 = 6'd0; cmd_a960 = 10'd0;
      class_out = 4'd0; class_out_valid = 1'b0; res_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      vec_cnt++;
      if ({acc_image, kernel_layer, offset_layer, image_in_valid} !== 789'd0) begin
         err_cnt++; $display("FAIL reset_bus: kl=%0d ol=%0d iiv=%b bus_nonzero=%b want all 0",
                             kernel_layer, offset_layer, image_in_valid, |acc_image);
      end
      vec_cnt++;
      if ({res_valid, res_class, err_addr, err_timeout, class_out_ready} !== 8'd0) begin
         err_cnt++; $display("FAIL reset_ctl: rv=%b rc=%0d ea=%b et=%b cor=%b want 0",
                             res_valid, res_class, err_addr, err_timeout, class_out_ready);
      end
      vec_cnt++;
      if (cmd_ready !== 1'b1) begin
         err_cnt++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready);
      end
      rst = 1'b0;
   endtask

   task automatic test_k1();
      logic [783:0] exp;
      exp = '0;
      exp[24:0] = 25'h1555555; exp[116:112] = 5'd17; exp[142:140] = 3'd4;
      drive_cmd(3'd1, 28'h1555555, 5'd17, 3'd4, 4'd0, 6'd0, 10'd0);
      vec_cnt++;
      if (kernel_layer !== 2'd1 || offset_layer !== 2'd0 || image_in_valid !== 1'b0) begin
         err_cnt++; $display("FAIL k1_strobe: kl=%0d ol=%0d iiv=%b want 1/0/0",
                             kernel_layer, offset_layer, image_in_valid);
      end
      vec_cnt++;
      if (acc_image !== exp) begin
         err_cnt++; $display("FAIL k1_bus: got %h want %h", acc_image[255:0], exp[255:0]);
      end
      @(posedge clk); #1;
      vec_cnt++;
      if (kernel_layer !== 2'd0 || acc_image !== 784'd0) begin
         err_cnt++; $display("FAIL k1_single_cycle: kl=%0d bus_nonzero=%b want 0/0",
                             kernel_layer, |acc_image);
      end
   endtask

   task automatic test_back_to_back();
      logic [783:0] exp;
      logic [27:0]  d;
      // OFF1 with out-of-range values only in fields it does not use
      exp = '0; exp[90:84] = 7'h55;
      drive_cmd(3'd4, 28'h0000055, 5'd0, 3'd7, 4'd12, 6'd63, 10'd1000);
      vec_cnt++;
      if (offset_layer !== 2'd1 || kernel_layer !== 2'd0 || err_addr !== 1'b0 || acc_image !== exp) begin
         err_cnt++; $display("FAIL off1_unused_fields: ol=%0d kl=%0d ea=%b got %h want %h",
                             offset_layer, kernel_layer, err_addr, acc_image[255:0], exp[255:0]);
      end
      d = 28'hFABCDEF;
      exp = '0; exp[24:0] = d[24:0]; exp[201:196] = 6'd59; exp[116:112] = 5'd5;
      drive_cmd(3'd2, d, 5'd5, 3'd0, 4'd0, 6'd59, 10'd0);
      vec_cnt++;
      if (kernel_layer !== 2'd2 || offset_layer !== 2'd0 || acc_image !== exp) begin
         err_cnt++; $display("FAIL k2_back_to_back: kl=%0d ol=%0d got %h want %h",
                             kernel_layer, offset_layer, acc_image[255:0], exp[255:0]);
      end
      drive_cmd(3'd0, 28'hFFFFFFF, 5'd31, 3'd7, 4'd15, 6'd63, 10'd1023);
      vec_cnt++;
      if (kernel_layer !== 2'd0 || offset_layer !== 2'd0 || acc_image !== 784'd0 || err_addr !== 1'b0) begin
         err_cnt++; $display("FAIL nop: kl=%0d ol=%0d bus_nonzero=%b ea=%b want 0",
                             kernel_layer, offset_layer, |acc_image, err_addr);
      end
   endtask

   task automatic test_addr_err();
      logic [783:0] exp;
      drive_cmd(3'd5, 28'h00001AB, 5'd0, 3'd0, 4'd0, 6'd60, 10'd0);
      vec_cnt++;
      if (offset_layer !== 2'd0 || kernel_layer !== 2'd0 || acc_image !== 784'd0 || err_addr !== 1'b1) begin
         err_cnt++; $display("FAIL off2_range: ol=%0d kl=%0d bus_nonzero=%b ea=%b want 0/0/0/1",
                             offset_layer, kernel_layer, |acc_image, err_addr);
      end
      exp = '0; exp[84] = 1'b1; exp[171:168] = 4'd9; exp[233:224] = 10'd959;
      drive_cmd(3'd3, 28'h0000001, 5'd0, 3'd0, 4'd9, 6'd0, 10'd959);
      vec_cnt++;
      if (kernel_layer !== 2'd3 || acc_image !== exp || err_addr !== 1'b1) begin
         err_cnt++; $display("FAIL fcb_max_addr: kl=%0d ea=%b got %h want %h",
                             kernel_layer, err_addr, acc_image[255:0], exp[255:0]);
      end
   endtask

   task automatic test_frame();
      logic [783:0] exp;
      logic [783:0] exp_fcm;
      exp = '0;
      for (int r = 0; r < 28; r++) exp[r*29] = 1'b1;
      exp_fcm = '0; exp_fcm[91:84] = 8'hA5;
      for (int r = 0; r < 28; r++) begin
         drive_cmd(3'd7, 28'h1 << r, 5'd0, 3'd0, 4'd0, 6'd0, 10'd0);
         if (r < 27) begin
            vec_cnt++;
            if (image_in_valid !== 1'b0) begin
               err_cnt++; $display("FAIL frame_early_launch: row %0d iiv=%b want 0", r, image_in_valid);
            end
         end
         if (r == 10) begin
            drive_cmd(3'd6, 28'h00000A5, 5'd3, 3'd0, 4'd0, 6'd0, 10'd0);
            vec_cnt++;
            if (offset_layer !== 2'd3 || image_in_valid !== 1'b0 || acc_image !== exp_fcm) begin
               err_cnt++; $display("FAIL fcm_interleave: ol=%0d iiv=%b got %h want %h",
                                   offset_layer, image_in_valid, acc_image[255:0], exp_fcm[255:0]);
            end
         end
      end
      vec_cnt++;
      if (image_in_valid !== 1'b1 || kernel_layer !== 2'd0 || offset_layer !== 2'd0 || cmd_ready !== 1'b0) begin
         err_cnt++; $display("FAIL launch_ctl: iiv=%b kl=%0d ol=%0d cr=%b want 1/0/0/0",
                             image_in_valid, kernel_layer, offset_layer, cmd_ready);
      end
      vec_cnt++;
      if (acc_image !== exp) begin
         err_cnt++; $display("FAIL launch_frame: got %h want %h", acc_image, exp);
      end
      @(posedge clk); #1;
      vec_cnt++;
      if (image_in_valid !== 1'b0 || class_out_ready !== 1'b1) begin
         err_cnt++; $display("FAIL wait_entry: iiv=%b cor=%b want 0/1", image_in_valid, class_out_ready);
      end
   endtask

   task automatic test_classify();
      repeat (49) @(posedge clk);
      #1;
      class_out = 4'd7; class_out_valid = 1'b1;
      @(posedge clk); #1;
      class_out = 4'd2;
      vec_cnt++;
      if (res_valid !== 1'b1 || res_class !== 4'd7 || cmd_ready !== 1'b0 || class_out_ready !== 1'b0) begin
         err_cnt++; $display("FAIL class_capture: rv=%b rc=%0d cr=%b cor=%b want 1/7/0/0",
                             res_valid, res_class, cmd_ready, class_out_ready);
      end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         vec_cnt++;
         if (res_valid !== 1'b1 || res_class !== 4'd7 || cmd_ready !== 1'b0) begin
            err_cnt++; $display("FAIL result_hold: cycle %0d rv=%b rc=%0d cr=%b want 1/7/0",
                                i, res_valid, res_class, cmd_ready);
         end
      end
      class_out_valid = 1'b0;
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      vec_cnt++;
      if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin
         err_cnt++; $display("FAIL result_handshake: cr=%b rv=%b want 1/0", cmd_ready, res_valid);
      end
   endtask

   task automatic test_timeout();
      for (int r = 0; r < 28; r++) drive_cmd(3'd7, 28'(r), 5'd0, 3'd0, 4'd0, 6'd0, 10'd0);
      @(posedge clk); #1;
      repeat (TMO - 1) @(posedge clk);
      #1;
      vec_cnt++;
      if (class_out_ready !== 1'b1 || err_timeout !== 1'b0) begin
         err_cnt++; $display("FAIL timeout_last_wait: cor=%b et=%b want 1/0", class_out_ready, err_timeout);
      end
      @(posedge clk); #1;
      vec_cnt++;
      if (err_timeout !== 1'b1 || cmd_ready !== 1'b1 || class_out_ready !== 1'b0 || res_valid !== 1'b0) begin
         err_cnt++; $display("FAIL timeout_fire: et=%b cr=%b cor=%b rv=%b want 1/1/0/0",
                             err_timeout, cmd_ready, class_out_ready, res_valid);
      end
      class_out = 4'd9; class_out_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      class_out_valid = 1'b0;
      vec_cnt++;
      if (res_valid !== 1'b0 || res_class !== 4'd7 || err_timeout !== 1'b1) begin
         err_cnt++; $display("FAIL late_class_ignored: rv=%b rc=%0d et=%b want 0/7/1",
                             res_valid, res_class, err_timeout);
      end
   endtask

   task automatic test_reset_abort();
      logic [783:0] exp;
      exp = '0;
      for (int r = 0; r < 28; r++) exp[r*29] = 1'b1;
      for (int r = 0; r < 3; r++) drive_cmd(3'd7, 28'hFFFFFFF, 5'd0, 3'd0, 4'd0, 6'd0, 10'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      vec_cnt++;
      if (cmd_ready !== 1'b1 || err_addr !== 1'b0 || err_timeout !== 1'b0) begin
         err_cnt++; $display("FAIL rst_clears: cr=%b ea=%b et=%b want 1/0/0", cmd_ready, err_addr, err_timeout);
      end
      for (int r = 0; r < 28; r++) begin
         drive_cmd(3'd7, 28'h1 << r, 5'd0, 3'd0, 4'd0, 6'd0, 10'd0);
         vec_cnt++;
         if (image_in_valid !== (r == 27)) begin
            err_cnt++; $display("FAIL rst_row_counter: row %0d iiv=%b want %b", r, image_in_valid, r == 27);
         end
      end
      vec_cnt++;
      if (acc_image !== exp) begin
         err_cnt++; $display("FAIL rst_frame: got %h want %h", acc_image, exp);
      end
      @(posedge clk); #1;
      rst = 1'b1; class_out = 4'd5; class_out_valid = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      class_out_valid = 1'b0;
      vec_cnt++;
      if (res_valid !== 1'b0 || class_out_ready !== 1'b0 || cmd_ready !== 1'b1 || res_class !== 4'd0) begin
         err_cnt++; $display("FAIL rst_abort_wait: rv=%b cor=%b cr=%b rc=%0d want 0/0/1/0",
                             res_valid, class_out_ready, cmd_ready, res_class);
      end
   endtask

   initial begin
      test_reset();
      test_k1();
      test_back_to_back();
      test_addr_err();
      test_frame();
      test_classify();
      test_timeout();
      test_reset_abort();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
